axi_llc_flush_seq: RTL and testbench



---
 rtl/axi_llc_flush_seq.sv | 219 +++++++++++++++++++++
 tb/tb_axi_llc_flush_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_flush_seq.sv
// Way-flush sequencer for the LLC configuration RegBus port: writes the flush
// mask, commits, then polls the flushed-status register until done or timeout.
module axi_llc_flush_seq #(
  parameter int unsigned SetAssociativity = 8,
  parameter logic [31:0] CfgBaseAddr      = 32'h0,
  parameter logic [31:0] FlushOffset      = 32'h10,
  parameter logic [31:0] CommitOffset     = 32'h18,
  parameter logic [31:0] FlushedOffset    = 32'h28,
  parameter int unsigned PollDelay        = 16,
  parameter int unsigned MaxPolls         = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_valid_i,
  input  logic [SetAssociativity-1:0] flush_ways_i,
  output logic                        flush_ready_o,
  output logic                        flush_done_o,
  output logic                        flush_error_o,
  output logic                        busy_o,
  output logic [31:0]                 conf_req_addr,
  output logic                        conf_req_w,
  output logic [31:0]                 conf_req_wdata,
  output logic [3:0]                  conf_req_wstrb,
  output logic                        conf_req_valid,
  input  logic [31:0]                 conf_resp_rdata,
  input  logic                        conf_resp_error,
  input  logic                        conf_resp_ready
);

  localparam int unsigned PW = $clog2(MaxPolls + 1);
  localparam int unsigned DW = (PollDelay > 1) ? $clog2(PollDelay) : 1;
  localparam logic [PW-1:0] POLL_MAX   = PW'(MaxPolls);
  localparam logic [DW-1:0] DELAY_LOAD = DW'(PollDelay - 1);

  if (SetAssociativity < 1 || SetAssociativity > 32) begin : g_bad_ways
    $error("SetAssociativity must be within 1..32");
  end
  if (PollDelay < 1) begin : g_bad_delay
    $error("PollDelay must be at least 1");
  end
  if (MaxPolls < 1) begin : g_bad_polls
    $error("MaxPolls must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_FLUSH,
    WR_COMMIT,
    RD_STATUS,
    WAIT,
    DONE
  } state_e;

  state_e                      state_reg, state_next;
  logic [SetAssociativity-1:0] mask_reg, mask_next;
  logic [PW-1:0]               poll_cnt_reg, poll_cnt_next;
  logic [DW-1:0]               delay_cnt_reg, delay_cnt_next;
  logic                        err_reg, err_next;

  logic [31:0] req_addr_reg, req_addr_next;
  logic        req_w_reg, req_w_next;
  logic [31:0] req_wdata_reg, req_wdata_next;
  logic [3:0]  req_wstrb_reg, req_wstrb_next;
  logic        req_valid_reg, req_valid_next;

  logic                        access_done;
  logic [SetAssociativity-1:0] way_flushed;
  logic                        all_flushed;
  logic                        unused_rdata;

  // A way counts as flushed if it was not requested or the status bit is set.
  for (genvar gi = 0; gi < SetAssociativity; gi++) begin : g_way
    assign way_flushed[gi] = conf_resp_rdata[gi] | ~mask_reg[gi];
  end
  assign all_flushed  = &way_flushed;
  assign unused_rdata = ^conf_resp_rdata;
  assign access_done  = req_valid_reg & conf_resp_ready;

  always_comb begin
    state_next     = state_reg;
    mask_next      = mask_reg;
    poll_cnt_next  = poll_cnt_reg;
    delay_cnt_next = delay_cnt_reg;
    err_next       = err_reg;

    case (state_reg)
      IDLE: begin
        if (flush_valid_i) begin
          mask_next     = flush_ways_i;
          poll_cnt_next = '0;
          err_next      = 1'b0;
          state_next    = (flush_ways_i == '0) ? DONE : WR_FLUSH;
        end
      end
      WR_FLUSH: begin
        if (access_done) begin
          if (conf_resp_error) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WR_COMMIT;
          end
        end
      end
      WR_COMMIT: begin
        if (access_done) begin
          if (conf_resp_error) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = RD_STATUS;
          end
        end
      end
      RD_STATUS: begin
        if (access_done) begin
          if (poll_cnt_reg != POLL_MAX) begin
            poll_cnt_next = poll_cnt_reg + 1'b1;
          end
          if (conf_resp_error) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else if (all_flushed) begin
            state_next = DONE;
          end else if (poll_cnt_next == POLL_MAX) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            delay_cnt_next = DELAY_LOAD;
            state_next     = WAIT;
          end
        end
      end
      WAIT: begin
        if (delay_cnt_reg == '0) begin
          state_next = RD_STATUS;
        end else begin
          delay_cnt_next = delay_cnt_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request fields are decoded from the upcoming state so they are registered
  // and constant for the whole access, including stalled cycles.
  always_comb begin
    req_addr_next  = 32'h0;
    req_w_next     = 1'b0;
    req_wdata_next = 32'h0;
    req_wstrb_next = 4'h0;
    req_valid_next = 1'b0;
    case (state_next)
      WR_FLUSH: begin
        req_addr_next  = CfgBaseAddr + FlushOffset;
        req_w_next     = 1'b1;
        req_wdata_next = 32'(mask_next);
        req_wstrb_next = 4'hF;
        req_valid_next = 1'b1;
      end
      WR_COMMIT: begin
        req_addr_next  = CfgBaseAddr + CommitOffset;
        req_w_next     = 1'b1;
        req_wdata_next = 32'h1;
        req_wstrb_next = 4'hF;
        req_valid_next = 1'b1;
      end
      RD_STATUS: begin
        req_addr_next  = CfgBaseAddr + FlushedOffset;
        req_valid_next = 1'b1;
      end
      default: begin
        req_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      mask_reg      <= '0;
      poll_cnt_reg  <= '0;
      delay_cnt_reg <= '0;
      err_reg       <= 1'b0;
      req_addr_reg  <= 32'h0;
      req_w_reg     <= 1'b0;
      req_wdata_reg <= 32'h0;
      req_wstrb_reg <= 4'h0;
      req_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      poll_cnt_reg  <= poll_cnt_next;
      delay_cnt_reg <= delay_cnt_next;
      err_reg       <= err_next;
      req_addr_reg  <= req_addr_next;
      req_w_reg     <= req_w_next;
      req_wdata_reg <= req_wdata_next;
      req_wstrb_reg <= req_wstrb_next;
      req_valid_reg <= req_valid_next;
    end
  end

  assign flush_ready_o  = (state_reg == IDLE);
  assign flush_done_o   = (state_reg == DONE);
  assign flush_error_o  = (state_reg == DONE) & err_reg;
  assign busy_o         = (state_reg != IDLE);
  assign conf_req_addr  = req_addr_reg;
  assign conf_req_w     = req_w_reg;
  assign conf_req_wdata = req_wdata_reg;
  assign conf_req_wstrb = req_wstrb_reg;
  assign conf_req_valid = req_valid_reg;

endmodule

// File: tb/tb_axi_llc_flush_seq.sv
// Directed bench for axi_llc_flush_seq: behavioural RegBus slave with
// configurable latency, status sequence and error injection.
module tb_axi_llc_flush_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_valid_i;
  logic [7:0]  flush_ways_i;
  logic        flush_ready_o, flush_done_o, flush_error_o, busy_o;
  logic [31:0] conf_req_addr, conf_req_wdata, conf_resp_rdata;
  logic        conf_req_w, conf_req_valid, conf_resp_error, conf_resp_ready;
  logic [3:0]  conf_req_wstrb;

  axi_llc_flush_seq #(.SetAssociativity(8), .PollDelay(16), .MaxPolls(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .flush_valid_i(flush_valid_i), .flush_ways_i(flush_ways_i),
    .flush_ready_o(flush_ready_o), .flush_done_o(flush_done_o),
    .flush_error_o(flush_error_o), .busy_o(busy_o),
    .conf_req_addr(conf_req_addr), .conf_req_w(conf_req_w),
    .conf_req_wdata(conf_req_wdata), .conf_req_wstrb(conf_req_wstrb),
    .conf_req_valid(conf_req_valid), .conf_resp_rdata(conf_resp_rdata),
    .conf_resp_error(conf_resp_error), .conf_resp_ready(conf_resp_ready)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic        w;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          cyc;
  } txn_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        w;
    logic [31:0] wdata;
  } vrec_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  txn_t        log_q[$];
  vrec_t       vq[$];
  logic [31:0] status_q[$];
  int          latency = 0;
  int          err_idx = -1;
  int          txn_idx = 0;
  int          stall = 0;
  int          valid_cycles = 0;
  int          hs_cyc, done_cyc;
  logic        done_err;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RegBus slave: decides ready/error/rdata on each falling edge.
  initial begin
    conf_resp_ready = 1'b0;
    conf_resp_error = 1'b0;
    conf_resp_rdata = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stall = 0;
        conf_resp_ready = 1'b0;
        conf_resp_error = 1'b0;
      end else if (conf_req_valid) begin
        valid_cycles++;
        if (latency > 0) vq.push_back('{conf_req_addr, conf_req_w, conf_req_wdata});
        if (stall < latency) begin
          stall++;
          conf_resp_ready = 1'b0;
          conf_resp_error = 1'b0;
        end else begin
          stall = 0;
          conf_resp_ready = 1'b1;
          conf_resp_error = (txn_idx == err_idx);
          if (conf_req_w) conf_resp_rdata = 32'h0;
          else if (status_q.size() > 1) conf_resp_rdata = status_q.pop_front();
          else if (status_q.size() == 1) conf_resp_rdata = status_q[0];
          else conf_resp_rdata = 32'h0;
          log_q.push_back('{conf_req_addr, conf_req_w, conf_req_wdata, conf_req_wstrb, cyc});
          $display("txn %0d cyc=%0d addr=%h w=%0b wdata=%h strb=%h rdata=%h err=%0b",
                   txn_idx, cyc, conf_req_addr, conf_req_w, conf_req_wdata, conf_req_wstrb,
                   conf_resp_rdata, conf_resp_error);
          txn_idx++;
        end
      end else begin
        conf_resp_ready = 1'b0;
        conf_resp_error = 1'b0;
      end
    end
  end

  task automatic setup_slave(input int lat, input int eidx);
    latency = lat;
    err_idx = eidx;
    txn_idx = 0;
    valid_cycles = 0;
    log_q.delete();
    vq.delete();
    status_q.delete();
  endtask

  task automatic send_req(input logic [7:0] m);
    int n = 0;
    @(negedge clk_i);
    flush_valid_i = 1'b1;
    flush_ways_i  = m;
    while (!flush_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check_val("req_accept_timeout", 32'd0, 32'd1);
    hs_cyc = cyc;
    @(posedge clk_i);
    #1;
    flush_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int   n = 0;
    logic got = 1'b0;
    while (n < budget && !got) begin
      @(negedge clk_i);
      if (flush_done_o) begin
        got      = 1'b1;
        done_cyc = cyc;
        done_err = flush_error_o;
        check_val("ready_low_in_done", {31'b0, flush_ready_o}, 32'd0);
      end
      n++;
    end
    if (!got) begin
      check_val("done_timeout", 32'd0, 32'd1);
      done_cyc = -1;
      done_err = 1'bx;
    end else begin
      @(negedge clk_i);
      check_val("done_one_cycle", {31'b0, flush_done_o}, 32'd0);
      check_val("ready_after_done", {31'b0, flush_ready_o}, 32'd1);
    end
  endtask

  task automatic check_txn(input string tag, input int i, input logic [31:0] a,
                           input logic w, input logic [31:0] d, input logic [3:0] s);
    if (i < log_q.size()) begin
      check_val({tag, "_addr"}, log_q[i].addr, a);
      check_val({tag, "_w"}, {31'b0, log_q[i].w}, {31'b0, w});
      if (w) check_val({tag, "_wdata"}, log_q[i].wdata, d);
      check_val({tag, "_strb"}, {28'b0, log_q[i].strb}, {28'b0, s});
    end else begin
      check_val({tag, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, {31'b0, flush_ready_o}, 32'd1);
    check_val({tag, "_done"}, {31'b0, flush_done_o}, 32'd0);
    check_val({tag, "_error"}, {31'b0, flush_error_o}, 32'd0);
    check_val({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    check_val({tag, "_valid"}, {31'b0, conf_req_valid}, 32'd0);
    check_val({tag, "_w"}, {31'b0, conf_req_w}, 32'd0);
    check_val({tag, "_addr"}, conf_req_addr, 32'd0);
    check_val({tag, "_wdata"}, conf_req_wdata, 32'd0);
    check_val({tag, "_wstrb"}, {28'b0, conf_req_wstrb}, 32'd0);
  endtask

  task automatic pulse_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_ni        = 1'b0;
    flush_valid_i = 1'b0;
    flush_ways_i  = 8'h0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    rst_ni = 1'b1;

    // Basic flush, zero-wait slave, complete on first read
    setup_slave(0, -1);
    status_q.push_back(32'h05);
    send_req(8'h05);
    wait_done(100);
    check_val("t1_latency", done_cyc - hs_cyc, 32'd4);
    check_val("t1_err", {31'b0, done_err}, 32'd0);
    check_val("t1_ntxn", log_q.size(), 32'd3);
    check_txn("t1_wr_flush", 0, 32'h10, 1'b1, 32'h05, 4'hF);
    check_txn("t1_wr_commit", 1, 32'h18, 1'b1, 32'h1, 4'hF);
    check_txn("t1_rd_status", 2, 32'h28, 1'b0, 32'h0, 4'h0);

    // Two polls with the PollDelay gap
    setup_slave(0, -1);
    status_q.push_back(32'h0F);
    status_q.push_back(32'hFF);
    send_req(8'hFF);
    wait_done(200);
    check_val("t2_err", {31'b0, done_err}, 32'd0);
    check_val("t2_ntxn", log_q.size(), 32'd4);
    if (log_q.size() == 4) check_val("t2_poll_gap", log_q[3].cyc - log_q[2].cyc, 32'd17);
    check_txn("t2_rd2", 3, 32'h28, 1'b0, 32'h0, 4'h0);

    // Timeout after MaxPolls reads
    setup_slave(0, -1);
    status_q.push_back(32'h0);
    send_req(8'h01);
    wait_done(500);
    check_val("t3_err", {31'b0, done_err}, 32'd1);
    check_val("t3_ntxn", log_q.size(), 32'd6);
    check_txn("t3_rd4", 5, 32'h28, 1'b0, 32'h0, 4'h0);

    // Error on the flush write, then a clean request
    setup_slave(0, 0);
    status_q.push_back(32'h03);
    send_req(8'h03);
    wait_done(100);
    check_val("t4_err", {31'b0, done_err}, 32'd1);
    check_val("t4_ntxn", log_q.size(), 32'd1);
    if (log_q.size() >= 1) check_val("t4_done_lat", done_cyc - log_q[0].cyc, 32'd1);
    setup_slave(0, -1);
    status_q.push_back(32'h03);
    send_req(8'h03);
    wait_done(100);
    check_val("t4b_err", {31'b0, done_err}, 32'd0);
    check_val("t4b_ntxn", log_q.size(), 32'd3);

    // Zero mask: immediate done, no bus traffic
    setup_slave(0, -1);
    send_req(8'h00);
    wait_done(20);
    check_val("t5_latency", done_cyc - hs_cyc, 32'd1);
    check_val("t5_err", {31'b0, done_err}, 32'd0);
    check_val("t5_valid_cycles", valid_cycles, 32'd0);

    // Stalling slave: request fields held on every valid cycle
    setup_slave(3, -1);
    status_q.push_back(32'h0A);
    send_req(8'h0A);
    wait_done(100);
    check_val("t6_latency", done_cyc - hs_cyc, 32'd13);
    check_val("t6_err", {31'b0, done_err}, 32'd0);
    check_val("t6_ncycles", vq.size(), 32'd12);
    for (int i = 0; i < 12 && i < vq.size(); i++) begin
      check_val($sformatf("t6_addr%0d", i), vq[i].addr,
                (i < 4) ? 32'h10 : (i < 8) ? 32'h18 : 32'h28);
      check_val($sformatf("t6_w%0d", i), {31'b0, vq[i].w}, (i < 8) ? 32'd1 : 32'd0);
      if (i < 8) check_val($sformatf("t6_wdata%0d", i), vq[i].wdata, (i < 4) ? 32'h0A : 32'h1);
    end

    // Reset during WAIT, then a fresh request
    setup_slave(0, -1);
    status_q.push_back(32'h0);
    send_req(8'h01);
    n = 0;
    while (log_q.size() < 3 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    check_val("t7_in_wait_busy", {31'b0, busy_o}, 32'd1);
    check_val("t7_in_wait_valid", {31'b0, conf_req_valid}, 32'd0);
    pulse_reset();
    setup_slave(0, -1);
    status_q.push_back(32'h02);
    send_req(8'h02);
    wait_done(100);
    check_val("t7_err", {31'b0, done_err}, 32'd0);
    check_val("t7_latency", done_cyc - hs_cyc, 32'd4);
    check_val("t7_ntxn", log_q.size(), 32'd3);

    // Reset during a stalled status read
    setup_slave(5, -1);
    status_q.push_back(32'h04);
    send_req(8'h04);
    n = 0;
    while (!(conf_req_valid && !conf_req_w) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check_val("t8_in_read", {31'b0, conf_req_valid & ~conf_req_w}, 32'd1);
    pulse_reset();
    setup_slave(0, -1);
    status_q.push_back(32'h04);
    send_req(8'h04);
    wait_done(100);
    check_val("t8_err", {31'b0, done_err}, 32'd0);
    check_val("t8_ntxn", log_q.size(), 32'd3);
    check_txn("t8_wr_flush", 0, 32'h10, 1'b1, 32'h04, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
